// File: rtl/mul_issue_scheduler_pkg.sv
// Shared definitions for the multiplier issue scheduler.
// Provides default geometry (register address width, unit latencies) and the
// shadow-pipeline entry type {valid, rd} used to track in-flight multiplies.
package mul_issue_scheduler_pkg;

    localparam int unsigned MIS_REG_ADDR_W  = 5;
    localparam int unsigned MIS_MUL_LATENCY = 3;
    localparam int unsigned MIS_ALU_LATENCY = 1;
    localparam int unsigned MIS_PERF_W      = 32;

    // One in-flight multiply: valid only when it will actually write a non-x0 register.
    typedef struct packed {
        logic                      valid;
        logic [MIS_REG_ADDR_W-1:0] rd;
    } shadow_entry_t;

endpackage

// File: rtl/mul_issue_scheduler_if.sv
// Decode/issue handshake bundle between the decode stage (master) and the
// multiplier issue scheduler (slave).
//   issue_*      : instruction presented by decode (valid, unit select, rd, rs1, rs2)
//   issue_ready  : scheduler accepts the presented instruction this cycle
//   mul_fire     : multiplier launch strobe
//   alu_fire     : ALU launch strobe
interface mul_issue_scheduler_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  issue_valid;
    logic                  issue_is_mul;
    logic                  issue_rd_en;
    logic [REG_ADDR_W-1:0] issue_rd_addr;
    logic                  issue_rs1_used;
    logic [REG_ADDR_W-1:0] issue_rs1_addr;
    logic                  issue_rs2_used;
    logic [REG_ADDR_W-1:0] issue_rs2_addr;
    logic                  issue_ready;
    logic                  mul_fire;
    logic                  alu_fire;

    modport master (
        output issue_valid, issue_is_mul, issue_rd_en, issue_rd_addr,
               issue_rs1_used, issue_rs1_addr, issue_rs2_used, issue_rs2_addr,
        input  issue_ready, mul_fire, alu_fire
    );

    modport slave (
        input  issue_valid, issue_is_mul, issue_rd_en, issue_rd_addr,
               issue_rs1_used, issue_rs1_addr, issue_rs2_used, issue_rs2_addr,
        output issue_ready, mul_fire, alu_fire
    );
endinterface

// File: rtl/mul_issue_scheduler_shadow_pipe.sv
// Shadow pipeline mirroring the multiplier: one {valid, rd} entry per stage.
// Index 0 is stage 1 (just issued), index MUL_LATENCY-1 is the writeback stage.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset (clears all entries)
//   advance              : shift when high, hold all stages when low
//   entry_in             : entry captured into stage 1 on advance
//   rs1/rs2/rd_addr      : addresses compared against every stage
//   stage_valid          : per-stage valid bits
//   rs1/rs2/rd_hit       : per-stage valid & address-match vectors
module mul_shadow_pipe
    import mul_issue_scheduler_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = MIS_MUL_LATENCY
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      advance,
    input  shadow_entry_t             entry_in,
    input  logic [MIS_REG_ADDR_W-1:0] rs1_addr,
    input  logic [MIS_REG_ADDR_W-1:0] rs2_addr,
    input  logic [MIS_REG_ADDR_W-1:0] rd_addr,
    output logic [MUL_LATENCY-1:0]    stage_valid,
    output logic [MUL_LATENCY-1:0]    rs1_hit,
    output logic [MUL_LATENCY-1:0]    rs2_hit,
    output logic [MUL_LATENCY-1:0]    rd_hit
);

    shadow_entry_t [MUL_LATENCY-1:0] entry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else if (advance) begin
            entry_q[0] <= entry_in;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                entry_q[k] <= entry_q[k-1];
            end
        end
    end

    always_comb begin
        stage_valid = '0;
        rs1_hit     = '0;
        rs2_hit     = '0;
        rd_hit      = '0;
        for (int k = 0; k < MUL_LATENCY; k++) begin
            stage_valid[k] = entry_q[k].valid;
            rs1_hit[k]     = entry_q[k].valid && (entry_q[k].rd == rs1_addr);
            rs2_hit[k]     = entry_q[k].valid && (entry_q[k].rd == rs2_addr);
            rd_hit[k]      = entry_q[k].valid && (entry_q[k].rd == rd_addr);
        end
    end

endmodule

// File: rtl/mul_issue_scheduler.sv
// Issue-side controller for the pipelined multiplier.
// Tracks in-flight multiplies, stalls decode on RAW/WAW hazards against pending
// mul results and on register-file write-port conflicts between ALU and mul.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   ext_stall      : downstream freeze; holds shadow pipe and counters
//   issue          : decode handshake (slave side)
//   mul_stall      : multiplier stall input (mirrors ext_stall)
//   wb_sel_mul     : write port owned by the multiplier result this cycle
//   inflight_cnt   : number of valid shadow stages
//   hazard_cycles  : saturating count of hazard-stalled issue cycles
// Entry widths come from the package; REG_ADDR_W must match MIS_REG_ADDR_W.
module mul_issue_scheduler
    import mul_issue_scheduler_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = MIS_MUL_LATENCY,
    parameter int unsigned ALU_LATENCY = MIS_ALU_LATENCY,
    parameter int unsigned REG_ADDR_W  = MIS_REG_ADDR_W,
    parameter int unsigned PERF_W      = MIS_PERF_W,
    localparam int unsigned CNT_W      = $clog2(MUL_LATENCY + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ext_stall,
    mul_issue_scheduler_if.slave    issue,
    output logic                    mul_stall,
    output logic                    wb_sel_mul,
    output logic [CNT_W-1:0]        inflight_cnt,
    output logic [PERF_W-1:0]       hazard_cycles
);

    localparam int unsigned PortStage = MUL_LATENCY - ALU_LATENCY - 1;
    localparam int unsigned WbStage   = MUL_LATENCY - 1;

    logic [REG_ADDR_W-1:0]  rd_addr;
    logic                   eff_rd_en;
    logic [MUL_LATENCY-1:0] stage_valid, rs1_hit, rs2_hit, rd_hit;
    logic                   raw_hazard, waw_hazard, port_hazard, hazard;
    logic                   mul_enter, mul_exit;
    shadow_entry_t          entry_in;
    logic [CNT_W-1:0]       inflight_q;
    logic [PERF_W-1:0]      hazard_q;

    assign rd_addr   = issue.issue_rd_addr;
    // x0 is hard-wired zero: never tracked, never a hazard source.
    assign eff_rd_en = issue.issue_rd_en && (rd_addr != '0);

    always_comb begin
        entry_in.valid = issue.mul_fire && eff_rd_en;
        entry_in.rd    = rd_addr;
    end

    mul_shadow_pipe #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_shadow_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (!ext_stall),
        .entry_in    (entry_in),
        .rs1_addr    (issue.issue_rs1_addr),
        .rs2_addr    (issue.issue_rs2_addr),
        .rd_addr     (rd_addr),
        .stage_valid (stage_valid),
        .rs1_hit     (rs1_hit),
        .rs2_hit     (rs2_hit),
        .rd_hit      (rd_hit)
    );

    // No bypass from the mul result: every pending stage blocks a reader.
    assign raw_hazard  = (issue.issue_rs1_used && |rs1_hit) || (issue.issue_rs2_used && |rs2_hit);
    assign waw_hazard  = eff_rd_en && |rd_hit;
    // An ALU op issued now would write back in the same cycle as the mul in this stage.
    assign port_hazard = !issue.issue_is_mul && eff_rd_en && stage_valid[PortStage];
    assign hazard      = raw_hazard || waw_hazard || port_hazard;

    assign issue.issue_ready = !ext_stall && !hazard;
    assign issue.mul_fire    = issue.issue_valid && issue.issue_ready && issue.issue_is_mul;
    assign issue.alu_fire    = issue.issue_valid && issue.issue_ready && !issue.issue_is_mul;

    assign mul_stall  = ext_stall;
    assign wb_sel_mul = stage_valid[WbStage] && !ext_stall;

    assign mul_enter = entry_in.valid;
    assign mul_exit  = stage_valid[WbStage];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            hazard_q   <= '0;
        end else begin
            if (!ext_stall) begin
                unique case ({mul_enter, mul_exit})
                    2'b10:   inflight_q <= inflight_q + 1'b1;
                    2'b01:   inflight_q <= inflight_q - 1'b1;
                    default: inflight_q <= inflight_q;
                endcase
            end
            if (issue.issue_valid && !ext_stall && hazard && !(&hazard_q)) begin
                hazard_q <= hazard_q + 1'b1;
            end
        end
    end

    assign inflight_cnt  = inflight_q;
    assign hazard_cycles = hazard_q;

endmodule

// File: tb/tb_mul_issue_scheduler.sv
module tb_mul_issue_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ext_stall = 1'b0;
    logic       mul_stall;
    logic       wb_sel_mul;
    logic [1:0] inflight_cnt;
    logic [3:0] hazard_cycles;

    int n_chk  = 0;
    int n_fail = 0;
    int wait_cnt = 0;
    bit alu_wb_next = 1'b0;
    bit alu_wb_now  = 1'b0;

    typedef struct packed {
        logic       is_mul;
        logic [4:0] rd;
        int         exp_wait;
    } exp_t;
    exp_t fire_q[$];

    mul_issue_scheduler_if #(.REG_ADDR_W(5)) bus ();

    mul_issue_scheduler #(
        .MUL_LATENCY (3),
        .ALU_LATENCY (1),
        .REG_ADDR_W  (5),
        .PERF_W      (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ext_stall     (ext_stall),
        .issue         (bus),
        .mul_stall     (mul_stall),
        .wb_sel_mul    (wb_sel_mul),
        .inflight_cnt  (inflight_cnt),
        .hazard_cycles (hazard_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Present one instruction and hold it until accepted; exp_w is the hand-computed stall count.
    task automatic issue(input logic m, input logic rde, input logic [4:0] rd,
                         input logic u1, input logic [4:0] r1,
                         input logic u2, input logic [4:0] r2, input int exp_w);
        exp_t e;
        bit done;
        e.is_mul = m; e.rd = rd; e.exp_wait = exp_w;
        fire_q.push_back(e);
        bus.issue_is_mul   = m;
        bus.issue_rd_en    = rde;
        bus.issue_rd_addr  = rd;
        bus.issue_rs1_used = u1;
        bus.issue_rs1_addr = r1;
        bus.issue_rs2_used = u2;
        bus.issue_rs2_addr = r2;
        bus.issue_valid    = 1'b1;
        wait_cnt = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus.issue_ready) begin
                done = 1'b1;
            end else begin
                wait_cnt++;
                if (wait_cnt > 40) begin
                    chk("issue_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        bus.issue_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pops the scoreboard on every launch and watches the write port.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            alu_wb_now  = alu_wb_next;
            alu_wb_next = 1'b0;
            if (alu_wb_now) chk("wb_port_collision", {31'd0, wb_sel_mul}, 0);
            chk("mul_stall_eq", {31'd0, mul_stall}, {31'd0, ext_stall});
            if (bus.mul_fire || bus.alu_fire) begin
                if (fire_q.size() == 0) begin
                    chk("unexpected_fire", 1, 0);
                end else begin
                    e = fire_q.pop_front();
                    chk("fire_unit", {31'd0, bus.mul_fire}, {31'd0, e.is_mul});
                    chk("fire_rd", {27'd0, bus.issue_rd_addr}, {27'd0, e.rd});
                    chk("fire_wait", wait_cnt, e.exp_wait);
                end
                if (bus.alu_fire && bus.issue_rd_en && bus.issue_rd_addr != 5'd0)
                    alu_wb_next = 1'b1;
            end
        end
    end

    initial begin
        int exp_cnt [8];
        exp_cnt = '{0, 1, 2, 3, 3, 2, 1, 0};
        bus.issue_valid = 0; bus.issue_is_mul = 0; bus.issue_rd_en = 0; bus.issue_rd_addr = 0;
        bus.issue_rs1_used = 0; bus.issue_rs1_addr = 0; bus.issue_rs2_used = 0;
        bus.issue_rs2_addr = 0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_inflight", {30'd0, inflight_cnt}, 0);
        chk("rst_hazard", {28'd0, hazard_cycles}, 0);
        chk("rst_ready", {31'd0, bus.issue_ready}, 1);
        chk("rst_mul_fire", {31'd0, bus.mul_fire}, 0);
        chk("rst_alu_fire", {31'd0, bus.alu_fire}, 0);
        chk("rst_wb_sel", {31'd0, wb_sel_mul}, 0);
        ext_stall = 1'b1; #1;
        chk("rst_ready_stalled", {31'd0, bus.issue_ready}, 0);
        ext_stall = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // 1. RAW: add x6<-x5+x1 behind mul x5 waits 3 cycles
        issue(1, 1, 5'd5, 1, 5'd1, 1, 5'd2, 0);
        issue(0, 1, 5'd6, 1, 5'd5, 1, 5'd1, 3);
        chk("t1_hazard_cycles", {28'd0, hazard_cycles}, 3);

        // 2. Port hazard: ALU op meeting the mul in stage 2 waits 1 cycle
        issue(1, 1, 5'd5, 1, 5'd1, 1, 5'd2, 0);
        idle(1);
        issue(0, 1, 5'd7, 1, 5'd1, 1, 5'd2, 1);
        chk("t2_hazard_cycles", {28'd0, hazard_cycles}, 4);

        // 3. Four independent muls back-to-back
        fork
            begin
                issue(1, 1, 5'd10, 1, 5'd1, 1, 5'd2, 0);
                issue(1, 1, 5'd11, 1, 5'd1, 1, 5'd2, 0);
                issue(1, 1, 5'd12, 1, 5'd1, 1, 5'd2, 0);
                issue(1, 1, 5'd13, 1, 5'd1, 1, 5'd2, 0);
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    chk("t3_inflight", {30'd0, inflight_cnt}, exp_cnt[i]);
                end
            end
        join
        @(posedge clk); #1;

        // 4. WAW on x5 waits until stage 3 retires; rd=x0 never stalls
        issue(1, 1, 5'd5, 1, 5'd1, 1, 5'd2, 0);
        issue(0, 1, 5'd5, 1, 5'd1, 1, 5'd2, 3);
        chk("t4_hazard_cycles", {28'd0, hazard_cycles}, 7);
        issue(1, 1, 5'd9, 1, 5'd1, 1, 5'd2, 0);
        idle(1);
        issue(0, 1, 5'd0, 1, 5'd1, 1, 5'd2, 0);

        // 5. ext_stall for 5 cycles with two muls in flight; dependent add presented throughout
        issue(1, 1, 5'd20, 1, 5'd1, 1, 5'd2, 0);
        issue(1, 1, 5'd21, 1, 5'd1, 1, 5'd2, 0);
        fork
            begin
                ext_stall = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    chk("t5_frozen_inflight", {30'd0, inflight_cnt}, 2);
                    chk("t5_frozen_wb", {31'd0, wb_sel_mul}, 0);
                    chk("t5_frozen_hazard", {28'd0, hazard_cycles}, 7);
                end
                @(posedge clk); #1 ext_stall = 1'b0;
                @(negedge clk); chk("t5_wb_c0", {31'd0, wb_sel_mul}, 0);
                @(negedge clk); chk("t5_wb_first", {31'd0, wb_sel_mul}, 1);
                @(negedge clk); chk("t5_wb_second", {31'd0, wb_sel_mul}, 1);
                @(negedge clk); chk("t5_wb_done", {31'd0, wb_sel_mul}, 0);
                chk("t5_hazard_cycles", {28'd0, hazard_cycles}, 9);
                chk("t5_inflight", {30'd0, inflight_cnt}, 0);
            end
            issue(0, 1, 5'd22, 1, 5'd20, 1, 5'd1, 7);
        join
        @(posedge clk); #1;

        // 6. Reset with three muls in flight, then hazard counter saturation
        issue(1, 1, 5'd1, 0, 5'd0, 0, 5'd0, 0);
        issue(1, 1, 5'd2, 0, 5'd0, 0, 5'd0, 0);
        issue(1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0);
        chk("t6_full_inflight", {30'd0, inflight_cnt}, 3);
        chk("t6_full_wb", {31'd0, wb_sel_mul}, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_inflight", {30'd0, inflight_cnt}, 0);
        chk("t6_rst_wb", {31'd0, wb_sel_mul}, 0);
        chk("t6_rst_hazard", {28'd0, hazard_cycles}, 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t6_no_wb_after_rst", {31'd0, wb_sel_mul}, 0);
        end
        @(posedge clk); #1;
        for (int r = 0; r < 6; r++) begin
            issue(1, 1, 5'd5, 1, 5'd1, 1, 5'd2, 0);
            issue(0, 1, 5'd6, 1, 5'd5, 1, 5'd1, 3);
            if (r == 3) chk("t6_hazard_12", {28'd0, hazard_cycles}, 12);
        end
        chk("t6_hazard_saturated", {28'd0, hazard_cycles}, 15);

        idle(2);
        chk("fire_queue_drained", fire_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
